video_pattern_axis_gen: RTL and testbench

Parametrised AXI4-Stream video test-pattern source, the successor to the random video generator used in testbenches. It emits frames of ACTIVE_HORI × ACTIVE_VERT pixels with tuser on the first pixel of each frame and tlast on the last pixel of each line. It provides four selectable data/timing modes built on a deterministic, synthesizable LFSR instead of `$random`. It sits at the head of the video pipeline in simulation and in on-chip self-test builds.

---
 rtl/video_tpg_pkg.sv | 23 ++
 rtl/video_pattern_axis_gen_lfsr.sv | 25 ++
 rtl/video_pattern_axis_gen.sv | 176 +++++++++++++++++
 tb/tb_video_pattern_axis_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_tpg_pkg.sv
// Shared constants for the video test-pattern source: pattern modes, FSM states
// and the Galois LFSR step used by both the generator and its LFSR sub-block.
package video_tpg_pkg;

  localparam logic [1:0] MODE_RAMP         = 2'd0;
  localparam logic [1:0] MODE_RANDOM       = 2'd1;
  localparam logic [1:0] MODE_CHECKER      = 2'd2;
  localparam logic [1:0] MODE_RANDOM_BURST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAN = 2'd1,
    ST_INTV = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois form: the feedback tap is bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/video_pattern_axis_gen_lfsr.sv
// 32-bit Galois LFSR; steps once per asserted advance, synchronous active-low reset.
module lfsr_galois32
  import video_tpg_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [31:0] state
);

  logic [31:0] state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else if (advance) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/video_pattern_axis_gen.sv
// AXI4-Stream video test-pattern source: frame/line counters, IDLE/TRAN/INTV
// sequencer, and a registered data mux for RAMP, RANDOM, CHECKER and RANDOM_BURST.
module video_pattern_axis_gen
  import video_tpg_pkg::*;
#(
  parameter int          DW          = 16,
  parameter int          ACTIVE_HORI = 1366,
  parameter int          ACTIVE_VERT = 768,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          enable,
  input  logic [1:0]    mode,
  output logic [DW-1:0] tdata_m,
  output logic          tlast_m,
  output logic          tuser_m,
  output logic          tvalid_m,
  input  logic          tready_m,
  output logic [15:0]   frame_cnt,
  output logic          frame_done
);

  localparam logic [15:0] PIX_LAST  = 16'(ACTIVE_HORI - 1);
  localparam logic [15:0] LINE_LAST = 16'(ACTIVE_VERT - 1);

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [15:0]   pix_q, pix_d;
  logic [15:0]   line_q, line_d;
  logic [5:0]    burst_q, burst_d;
  logic [4:0]    gap_q, gap_d;
  logic [4:0]    gap_cnt_q, gap_cnt_d;
  logic [DW-1:0] tdata_q;
  logic          tvalid_q, tlast_q, tuser_q;
  logic [15:0]   frame_cnt_q;
  logic          frame_done_q;
  logic [31:0]   lfsr_q, lfsr_d;
  logic          accept, line_end, frame_end, burst_end, burst_load;

  function automatic logic [DW-1:0] pixel_data(input logic [1:0]  m,
                                               input logic [15:0] p,
                                               input logic [15:0] l,
                                               input logic [31:0] r);
    logic [31:0] sum;
    sum = {16'h0, p} + {16'h0, l};
    case (m)
      MODE_RAMP:    return sum[DW-1:0];
      MODE_CHECKER: return (p[3] ^ l[3]) ? {DW{1'b1}} : {DW{1'b0}};
      default:      return r[DW-1:0];
    endcase
  endfunction

  function automatic logic [5:0] draw_len(input logic [31:0] r);
    return {1'b0, r[20:16]} + 6'd1;
  endfunction

  function automatic logic [4:0] draw_gap(input logic [31:0] r);
    return r[28:24];
  endfunction

  lfsr_galois32 #(.SEED(SEED)) u_lfsr (
    .clk     (aclk),
    .rst_n   (aresetn),
    .advance (accept),
    .state   (lfsr_q)
  );

  assign accept    = tvalid_q & tready_m;
  assign line_end  = (pix_q == PIX_LAST);
  assign frame_end = line_end && (line_q == LINE_LAST);
  assign burst_end = (mode_q == MODE_RANDOM_BURST) && (burst_q == 6'd1);
  assign lfsr_d    = accept ? lfsr_step(lfsr_q) : lfsr_q;

  always_comb begin
    pix_d  = pix_q;
    line_d = line_q;
    if (accept) begin
      if (line_end) begin
        pix_d  = 16'd0;
        line_d = (line_q == LINE_LAST) ? 16'd0 : line_q + 16'd1;
      end else begin
        pix_d = pix_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    burst_d    = burst_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    burst_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_TRAN;
          mode_d     = mode;
          burst_load = 1'b1;
        end
      end
      ST_TRAN: begin
        if (accept) begin
          if (frame_end && !enable) begin
            state_d = ST_IDLE;
          end else begin
            if (frame_end) mode_d = mode;
            if (burst_end && (gap_q != 5'd0)) begin
              state_d   = ST_INTV;
              gap_cnt_d = gap_q;
            end else if (burst_end || (mode_q != MODE_RANDOM_BURST)) begin
              // Outside burst mode the draw is kept fresh so a switch into it starts cleanly.
              burst_load = 1'b1;
            end else begin
              burst_d = burst_q - 6'd1;
            end
          end
        end
      end
      ST_INTV: begin
        gap_cnt_d = gap_cnt_q - 5'd1;
        if (gap_cnt_q == 5'd1) begin
          state_d    = ST_TRAN;
          burst_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (burst_load) begin
      burst_d = draw_len(lfsr_d);
      gap_d   = draw_gap(lfsr_d);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_RAMP;
      pix_q        <= 16'd0;
      line_q       <= 16'd0;
      burst_q      <= 6'd1;
      gap_q        <= 5'd0;
      gap_cnt_q    <= 5'd0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b1;
      frame_cnt_q  <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      pix_q        <= pix_d;
      line_q       <= line_d;
      burst_q      <= burst_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      // Outputs are built from next-state values so they stay registered yet current.
      tdata_q      <= pixel_data(mode_d, pix_d, line_d, lfsr_d);
      tvalid_q     <= (state_d == ST_TRAN);
      tlast_q      <= (pix_d == PIX_LAST);
      tuser_q      <= (pix_d == 16'd0) && (line_d == 16'd0);
      frame_done_q <= accept && frame_end;
      if (accept && frame_end) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign tdata_m    = tdata_q;
  assign tvalid_m   = tvalid_q;
  assign tlast_m    = tlast_q;
  assign tuser_m    = tuser_q;
  assign frame_cnt  = frame_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_video_pattern_axis_gen.sv
// Directed bench for video_pattern_axis_gen: vector table for RAMP/RANDOM timing,
// a CHECKER sequence on a wider second instance, and a modelled RANDOM_BURST run.
module tb_video_pattern_axis_gen;

  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          tready_m = 1'b0;
  logic [DW-1:0] tdata_m;
  logic          tlast_m, tuser_m, tvalid_m, frame_done;
  logic [15:0]   frame_cnt;

  logic          en_c = 1'b0;
  logic [1:0]    mode_c = 2'd2;
  logic          rdy_c = 1'b1;
  logic [7:0]    tdata_c;
  logic          tlast_c, tuser_c, tvalid_c, done_c;
  logic [15:0]   fc_c;

  video_pattern_axis_gen #(.DW(DW), .ACTIVE_HORI(4), .ACTIVE_VERT(2), .SEED(32'h1)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .mode(mode),
    .tdata_m(tdata_m), .tlast_m(tlast_m), .tuser_m(tuser_m), .tvalid_m(tvalid_m),
    .tready_m(tready_m), .frame_cnt(frame_cnt), .frame_done(frame_done)
  );

  video_pattern_axis_gen #(.DW(8), .ACTIVE_HORI(12), .ACTIVE_VERT(2), .SEED(32'h1)) dut_chk (
    .aclk(aclk), .aresetn(aresetn), .enable(en_c), .mode(mode_c),
    .tdata_m(tdata_c), .tlast_m(tlast_c), .tuser_m(tuser_c), .tvalid_m(tvalid_c),
    .tready_m(rdy_c), .frame_cnt(fc_c), .frame_done(done_c)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  typedef struct {
    logic        rstn;
    logic        en;
    logic [1:0]  md;
    logic        rdy;
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        u;
    logic        dn;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rstn, input logic en, input logic [1:0] md,
                              input logic rdy, input logic v, input logic [15:0] d,
                              input logic l, input logic u, input logic dn,
                              input logic [15:0] fc);
    vec_t t;
    t.rstn = rstn; t.en = en; t.md = md; t.rdy = rdy;
    t.v = v; t.d = d; t.l = l; t.u = u; t.dn = dn; t.fc = fc;
    vecs.push_back(t);
  endfunction

  // RANDOM_BURST monitor state
  logic        mon_on = 1'b0;
  logic [31:0] m_lfsr = 32'h1;
  logic        started = 1'b0, gap_pend = 1'b0, seen_frame = 1'b0;
  int          burst_left = 0, g_cur = 0, exp_gap = 0, gap_seen = 0;
  int          fbeats = 0, beats_total = 0;
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_u = 1'b0;
  logic [15:0] prev_d = 16'h0;

  always @(negedge aclk) begin
    if (mon_on) begin
      if (prev_v && !prev_r)
        check("burst_hold", {13'h0, tvalid_m, tdata_m, tlast_m, tuser_m},
              {13'h0, 1'b1, prev_d, prev_l, prev_u});
      if (tvalid_m) begin
        if (!started) begin
          started    = 1'b1;
          burst_left = int'(m_lfsr[20:16]) + 1;
          g_cur      = int'(m_lfsr[28:24]);
        end else if (gap_pend) begin
          check("burst_gap", gap_seen, exp_gap);
          gap_pend = 1'b0;
        end else if (gap_seen != 0) begin
          check("burst_unexpected_gap", gap_seen, 0);
        end
        gap_seen = 0;
        if (tready_m) begin
          check("burst_data", {16'h0, tdata_m}, {16'h0, m_lfsr[15:0]});
          if (tuser_m) begin
            if (seen_frame) check("frame_beats", fbeats, 8);
            fbeats     = 0;
            seen_frame = 1'b1;
          end
          fbeats++;
          beats_total++;
          m_lfsr = tb_step(m_lfsr);
          burst_left--;
          if (burst_left == 0) begin
            exp_gap    = g_cur;
            gap_pend   = 1'b1;
            burst_left = int'(m_lfsr[20:16]) + 1;
            g_cur      = int'(m_lfsr[28:24]);
          end
        end
      end else if (started) begin
        gap_seen++;
      end
      prev_v = tvalid_m;
      prev_r = tready_m;
      prev_d = tdata_m;
      prev_l = tlast_m;
      prev_u = tuser_m;
    end
  end

  initial begin
    // rstn en md rdy | valid data last user done fcnt
    add(1, 1, 0, 1,  1, 16'd0, 0, 1, 0, 16'd0);
    add(1, 1, 0, 1,  1, 16'd1, 0, 0, 0, 16'd0);
    add(1, 1, 0, 1,  1, 16'd2, 0, 0, 0, 16'd0);
    add(1, 1, 0, 1,  1, 16'd3, 1, 0, 0, 16'd0);
    add(1, 1, 0, 1,  1, 16'd1, 0, 0, 0, 16'd0);
    add(1, 1, 0, 1,  1, 16'd2, 0, 0, 0, 16'd0);
    add(1, 1, 0, 1,  1, 16'd3, 0, 0, 0, 16'd0);
    add(1, 1, 0, 1,  1, 16'd4, 1, 0, 0, 16'd0);
    add(1, 0, 0, 1,  0, 16'd0, 0, 1, 1, 16'd1);
    add(1, 0, 0, 1,  0, 16'd0, 0, 1, 0, 16'd1);
    // second frame with a three-cycle stall on beat 2, mode/enable changed mid-frame
    add(1, 1, 0, 0,  1, 16'd0, 0, 1, 0, 16'd1);
    add(1, 1, 0, 1,  1, 16'd1, 0, 0, 0, 16'd1);
    add(1, 1, 0, 1,  1, 16'd2, 0, 0, 0, 16'd1);
    add(1, 1, 0, 0,  1, 16'd2, 0, 0, 0, 16'd1);
    add(1, 1, 0, 0,  1, 16'd2, 0, 0, 0, 16'd1);
    add(1, 1, 0, 0,  1, 16'd2, 0, 0, 0, 16'd1);
    add(1, 1, 0, 1,  1, 16'd3, 1, 0, 0, 16'd1);
    add(1, 1, 0, 1,  1, 16'd1, 0, 0, 0, 16'd1);
    add(1, 1, 2, 1,  1, 16'd2, 0, 0, 0, 16'd1);
    add(1, 0, 2, 1,  1, 16'd3, 0, 0, 0, 16'd1);
    add(1, 0, 2, 1,  1, 16'd4, 1, 0, 0, 16'd1);
    add(1, 0, 2, 1,  0, 16'd0, 0, 1, 1, 16'd2);
    add(1, 0, 2, 1,  0, 16'd0, 0, 1, 0, 16'd2);
    // reset mid-stream, then RANDOM from SEED = 1
    add(0, 0, 0, 0,  0, 16'd0, 0, 1, 0, 16'd0);
    add(1, 1, 1, 0,  1, 16'h0001, 0, 1, 0, 16'd0);
    add(1, 1, 1, 1,  1, 16'h0003, 0, 0, 0, 16'd0);
    add(1, 1, 1, 1,  1, 16'h0002, 0, 0, 0, 16'd0);
    add(1, 1, 1, 1,  1, 16'h0001, 1, 0, 0, 16'd0);
    add(1, 0, 1, 1,  1, 16'h0003, 0, 0, 0, 16'd0);

    aresetn = 1'b0;
    enable  = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    check("reset_valid", tvalid_m, 0);
    check("reset_user", tuser_m, 1);
    check("reset_last", tlast_m, 0);
    check("reset_data", tdata_m, 0);
    check("reset_fcnt", frame_cnt, 0);
    check("reset_done", frame_done, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      aresetn  = vecs[i].rstn;
      enable   = vecs[i].en;
      mode     = vecs[i].md;
      tready_m = vecs[i].rdy;
      @(posedge aclk);
      #1;
      check($sformatf("vec%0d_valid", i), tvalid_m, vecs[i].v);
      check($sformatf("vec%0d_data", i), tdata_m, vecs[i].d);
      check($sformatf("vec%0d_last", i), tlast_m, vecs[i].l);
      check($sformatf("vec%0d_user", i), tuser_m, vecs[i].u);
      check($sformatf("vec%0d_done", i), frame_done, vecs[i].dn);
      check($sformatf("vec%0d_fcnt", i), frame_cnt, vecs[i].fc);
    end

    // CHECKER on a 12x2, 8-bit instance: pixels 8..11 of each line are all-ones
    en_c = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge aclk);
      #1;
      check($sformatf("chk%0d_valid", i), tvalid_c, 1);
      check($sformatf("chk%0d_data", i), tdata_c, ((i % 12) >= 8) ? 8'hFF : 8'h00);
      check($sformatf("chk%0d_last", i), tlast_c, ((i % 12) == 11) ? 1 : 0);
      check($sformatf("chk%0d_user", i), tuser_c, (i == 0) ? 1 : 0);
    end
    en_c = 1'b0;

    // RANDOM_BURST with random backpressure over 10 frames
    aresetn  = 1'b0;
    enable   = 1'b0;
    mode     = 2'd3;
    tready_m = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    m_lfsr  = 32'h1;
    mon_on  = 1'b1;
    aresetn = 1'b1;
    enable  = 1'b1;
    for (int cyc = 0; cyc < 20000 && frame_cnt < 16'd10; cyc++) begin
      tready_m = 1'($urandom_range(0, 1));
      @(posedge aclk);
      #1;
    end
    mon_on = 1'b0;
    check("burst_frames_reached", (frame_cnt >= 16'd10) ? 1 : 0, 1);
    check("burst_beats_seen", (beats_total >= 80) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
